// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types for the hazard detection unit: instruction hazard classes and forward selects.
// Used by every build; HDU_MULTICYCLE_EN only changes how OP_MUL is handled.
package hdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_ALU   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_MUL   = 3'd4
    } hazard_optype_t;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EXE     = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Bundle between the ID-stage pipeline control and the hazard unit.
// The pipeline side uses 'master' and the hazard unit uses 'slave'; HDU_MULTICYCLE_EN does not change it.
interface hazard_ctrl_mc_if
    import hdu_pkg::*;
#(
    parameter int REG_AW = 5
);
    logic                  Branch_ID;
    logic                  rs1use_ID;
    logic                  rs2use_ID;
    hazard_optype_t        hazard_optype_ID;
    logic [REG_AW-1:0]     rs1_ID;
    logic [REG_AW-1:0]     rs2_ID;
    logic [REG_AW-1:0]     rd_EXE;
    logic [REG_AW-1:0]     rd_MEM;
    logic [REG_AW-1:0]     rs2_EXE;
    logic                  cmu_stall;

    logic                  PC_EN_IF;
    logic                  reg_FD_EN;
    logic                  reg_FD_stall;
    logic                  reg_FD_flush;
    logic                  reg_DE_EN;
    logic                  reg_DE_flush;
    logic                  reg_EM_EN;
    logic                  reg_EM_flush;
    logic                  reg_MW_EN;
    logic [1:0]            forward_ctrl_A;
    logic [1:0]            forward_ctrl_B;
    logic                  forward_ctrl_ls;
    logic                  mul_busy;

    modport master (
        output Branch_ID, rs1use_ID, rs2use_ID, hazard_optype_ID,
               rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE, cmu_stall,
        input  PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mul_busy
    );

    modport slave (
        input  Branch_ID, rs1use_ID, rs2use_ID, hazard_optype_ID,
               rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE, cmu_stall,
        output PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mul_busy
    );

endinterface

// File: rtl/hazard_ctrl_mc_mul_lat_counter.sv
// MUL occupancy countdown: load on MUL entry into EXE, count down unless frozen.
// Only present when HDU_MULTICYCLE_EN is defined.
`ifdef HDU_MULTICYCLE_EN
module mul_lat_counter #(
    parameter int               CNT_W    = 3,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic freeze,
    output logic busy
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0 && !freeze) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule
`endif

// File: rtl/hazard_ctrl_mc.sv
// Hazard detection / forwarding control for the 5-stage RV32 pipe (load-use, store exemption, multi-cycle MUL).
// HDU_MULTICYCLE_EN enables the multi-cycle MUL; without it MUL behaves exactly like ALU.
module hazard_ctrl_mc
    import hdu_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
    input logic             clk,
    input logic             rst,
    hazard_ctrl_mc_if.slave hif
);
    hazard_optype_t op_exe_q, op_exe_d;
    hazard_optype_t op_mem_q, op_mem_d;

    logic mul_busy, mul_done;
    logic load_stall, any_stall;
    logic de_en, de_flush, em_en, em_flush;
    logic exe_res, mem_alu, mem_ld;

    // Marker block only appears in the elaborated hierarchy for an out-of-range configuration.
    if (MUL_LAT < 1 || MUL_LAT > 15 || CNT_W < $clog2(MUL_LAT + 1)) begin : g_illegal_mul_cfg
    end

    function automatic logic hit(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rd);
        return (rs == rd) && (rd != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic exe_hit,
                                           input logic mem_hit, input logic exe_ok,
                                           input logic mem_ok_alu, input logic mem_ok_ld);
        if (!use_rs)                 return FWD_RF;
        if (exe_hit && exe_ok)       return FWD_EXE;
        if (mem_hit && mem_ok_alu)   return FWD_MEM_ALU;
        if (mem_hit && mem_ok_ld)    return FWD_MEM_LD;
        return FWD_RF;
    endfunction

`ifdef HDU_MULTICYCLE_EN
    logic mul_load, cnt_busy;

    assign mul_load = de_en && !de_flush && (hif.hazard_optype_ID == OP_MUL);

    mul_lat_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (CNT_W'(MUL_LAT - 1))
    ) u_mul_lat_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (mul_load),
        .freeze (hif.cmu_stall),
        .busy   (cnt_busy)
    );

    assign mul_busy = (op_exe_q == OP_MUL) && cnt_busy;
    assign mul_done = !cnt_busy;
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b1;
`endif

    assign exe_res = (op_exe_q == OP_ALU) || ((op_exe_q == OP_MUL) && mul_done);
    assign mem_alu = (op_mem_q == OP_ALU) || (op_mem_q == OP_MUL);
    assign mem_ld  = (op_mem_q == OP_LOAD);

    // Store data is picked up later from MEM, so an rs2-only match never stalls a store.
    assign load_stall = (op_exe_q == OP_LOAD) &&
                        ((hif.rs1use_ID && hit(hif.rs1_ID, hif.rd_EXE)) ||
                         (hif.rs2use_ID && hit(hif.rs2_ID, hif.rd_EXE) &&
                          (hif.hazard_optype_ID != OP_STORE)));
    assign any_stall  = load_stall | mul_busy;

    assign de_en    = ~hif.cmu_stall & ~mul_busy;
    assign de_flush = load_stall;
    assign em_en    = ~hif.cmu_stall;
    assign em_flush = mul_busy;

    always_comb begin
        op_exe_d = op_exe_q;
        op_mem_d = op_mem_q;
        if (de_en) begin
            op_exe_d = de_flush ? OP_NONE : hif.hazard_optype_ID;
        end
        if (em_en) begin
            op_mem_d = em_flush ? OP_NONE : op_exe_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_exe_q <= OP_NONE;
            op_mem_q <= OP_NONE;
        end else begin
            op_exe_q <= op_exe_d;
            op_mem_q <= op_mem_d;
        end
    end

    assign hif.PC_EN_IF     = ~hif.cmu_stall & ~any_stall;
    assign hif.reg_FD_EN    = ~hif.cmu_stall;
    assign hif.reg_FD_stall = any_stall;
    assign hif.reg_FD_flush = hif.Branch_ID & ~any_stall & ~hif.cmu_stall;
    assign hif.reg_DE_EN    = de_en;
    assign hif.reg_DE_flush = de_flush;
    assign hif.reg_EM_EN    = em_en;
    assign hif.reg_EM_flush = em_flush;
    assign hif.reg_MW_EN    = ~hif.cmu_stall;
    assign hif.mul_busy     = mul_busy;

    assign hif.forward_ctrl_A = fwd_sel(hif.rs1use_ID, hit(hif.rs1_ID, hif.rd_EXE),
                                        hit(hif.rs1_ID, hif.rd_MEM), exe_res, mem_alu, mem_ld);
    assign hif.forward_ctrl_B = fwd_sel(hif.rs2use_ID, hit(hif.rs2_ID, hif.rd_EXE),
                                        hit(hif.rs2_ID, hif.rd_MEM), exe_res, mem_alu, mem_ld);
    assign hif.forward_ctrl_ls = hit(hif.rs2_EXE, hif.rd_MEM) &&
                                 (op_exe_q == OP_STORE) && (op_mem_q == OP_LOAD);

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: directed cycles push expected outputs, a negedge monitor compares.
// MUL expectations follow HDU_MULTICYCLE_EN (MUL_LAT=4 when defined, MUL as ALU otherwise).
module tb_hazard_ctrl_mc;
    import hdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.REG_AW(5)) hif ();

    hazard_ctrl_mc #(.REG_AW(5), .MUL_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    typedef struct {
        string       name;
        logic [14:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // {PC_EN, FD_EN, FD_stall, FD_flush, DE_EN, DE_flush, EM_EN, EM_flush, MW_EN, fwdA, fwdB, ls, busy}
    function automatic logic [14:0] ev(input logic [1:0] fa, input logic [1:0] fb, input logic ls,
                                       input logic lstall, input logic mbusy, input logic cmu,
                                       input logic br);
        logic st;
        st = lstall | mbusy;
        return {~cmu & ~st, ~cmu, st, br & ~st & ~cmu, ~cmu & ~mbusy, lstall,
                ~cmu, mbusy, ~cmu, fa, fb, ls, mbusy};
    endfunction

    task automatic chk(input string nm, input logic [14:0] e);
        exp_t x;
        x.name = nm;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.Branch_ID        = 1'b0;
        hif.rs1use_ID        = 1'b0;
        hif.rs2use_ID        = 1'b0;
        hif.hazard_optype_ID = OP_NONE;
        hif.rs1_ID           = 5'd0;
        hif.rs2_ID           = 5'd0;
        hif.rd_EXE           = 5'd0;
        hif.rd_MEM           = 5'd0;
        hif.rs2_EXE          = 5'd0;
        hif.cmu_stall        = 1'b0;
    endtask

    task automatic dep7();
        idle();
        hif.hazard_optype_ID = OP_ALU;
        hif.rd_EXE           = 5'd7;
        hif.rs1_ID           = 5'd7;
        hif.rs1use_ID        = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] act;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {hif.PC_EN_IF, hif.reg_FD_EN, hif.reg_FD_stall, hif.reg_FD_flush,
                   hif.reg_DE_EN, hif.reg_DE_flush, hif.reg_EM_EN, hif.reg_EM_flush,
                   hif.reg_MW_EN, hif.forward_ctrl_A, hif.forward_ctrl_B,
                   hif.forward_ctrl_ls, hif.mul_busy};
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();

        // ALU forwarding, x0 exclusion, EXE priority over MEM
        idle(); hif.hazard_optype_ID = OP_ALU;
        tick();
        idle(); hif.hazard_optype_ID = OP_ALU; hif.rd_EXE = 5'd5; hif.rs1_ID = 5'd5; hif.rs1use_ID = 1'b1;
        chk("alu_exe_fwd", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        idle(); hif.hazard_optype_ID = OP_ALU; hif.rs1use_ID = 1'b1;
        hif.rd_MEM = 5'd5; hif.rs2_ID = 5'd5; hif.rs2use_ID = 1'b1;
        chk("x0_and_mem_alu", ev(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        idle(); hif.rd_EXE = 5'd9; hif.rd_MEM = 5'd9; hif.rs1_ID = 5'd9; hif.rs1use_ID = 1'b1;
        chk("exe_over_mem", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();

        // Load-use: one bubble, branch suppressed while stalled
        idle(); hif.hazard_optype_ID = OP_LOAD;
        tick();
        idle(); hif.hazard_optype_ID = OP_ALU; hif.rd_EXE = 5'd6; hif.rs1_ID = 5'd6; hif.rs1use_ID = 1'b1;
        hif.Branch_ID = 1'b1;
        chk("load_use_stall_br", ev(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        tick();
        idle(); hif.hazard_optype_ID = OP_ALU; hif.rd_MEM = 5'd6; hif.rs1_ID = 5'd6; hif.rs1use_ID = 1'b1;
        chk("load_fwd_mem_ld", ev(2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();

        // Store exemption on rs2, store data forward, rs1 still stalls
        idle(); hif.hazard_optype_ID = OP_LOAD;
        tick();
        idle(); hif.hazard_optype_ID = OP_STORE; hif.rd_EXE = 5'd6;
        hif.rs2_ID = 5'd6; hif.rs2use_ID = 1'b1; hif.rs1_ID = 5'd2; hif.rs1use_ID = 1'b1;
        hif.Branch_ID = 1'b1;
        chk("store_rs2_exempt_br", ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        idle(); hif.rs2_EXE = 5'd6; hif.rd_MEM = 5'd6;
        chk("store_data_fwd_ls", ev(2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        idle(); hif.hazard_optype_ID = OP_LOAD;
        tick();
        idle(); hif.hazard_optype_ID = OP_STORE; hif.rd_EXE = 5'd6; hif.rs1_ID = 5'd6; hif.rs1use_ID = 1'b1;
        chk("store_rs1_stall", ev(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();

        // MUL with dependent instruction in ID
        idle(); hif.hazard_optype_ID = OP_MUL;
        tick();
`ifdef HDU_MULTICYCLE_EN
        for (int i = 0; i < 3; i++) begin
            dep7();
            chk($sformatf("mul_busy_%0d", i), ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            tick();
        end
        dep7();
        chk("mul_done_fwd", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
`else
        dep7();
        chk("mul_as_alu", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
`endif
        idle(); hif.rd_MEM = 5'd7; hif.rs1_ID = 5'd7; hif.rs1use_ID = 1'b1;
        chk("mul_mem_fwd", ev(2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();

        // MUL stretched by cache-miss freeze
        idle(); hif.hazard_optype_ID = OP_MUL;
        tick();
`ifdef HDU_MULTICYCLE_EN
        for (int i = 0; i < 5; i++) begin
            dep7();
            hif.cmu_stall = (i == 1 || i == 2);
            chk($sformatf("mul_cmu_busy_%0d", i),
                ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, (i == 1 || i == 2), 1'b0));
            tick();
        end
        dep7();
        chk("mul_cmu_done", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
`else
        dep7();
        chk("mul_alu_fwd2", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        dep7(); hif.cmu_stall = 1'b1;
        chk("cmu_freeze", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
`endif

        // Reset in the middle of a MUL
        idle(); hif.hazard_optype_ID = OP_MUL;
        tick();
        dep7();
`ifdef HDU_MULTICYCLE_EN
        chk("mul_before_reset", ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        chk("mul_before_reset", ev(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dep7();
        chk("post_reset", ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();

`ifdef HDU_MULTICYCLE_EN
        // Back-to-back MULs: second enters on the edge the first finishes
        idle(); hif.hazard_optype_ID = OP_MUL;
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); hif.hazard_optype_ID = OP_MUL;
            chk($sformatf("b2b_first_%0d", i), ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            tick();
        end
        idle(); hif.hazard_optype_ID = OP_MUL;
        chk("b2b_handoff", ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        idle();
        chk("b2b_second_busy", ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
`endif

        idle();
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
